// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multicycle RISC-V control FSM.
// Holds state enum, opcode constants, datapath select encodings and ALU opcodes.
package mc_ctrl_pkg;

  localparam int unsigned OP_W  = 7;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned ALU_W = 4;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI
  } state_t;

  typedef enum logic [1:0] {
    ALU_MODE_ADD,
    ALU_MODE_RTYPE,
    ALU_MODE_ITYPE,
    ALU_MODE_BRANCH
  } alu_mode_t;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  localparam logic             ADR_PC       = 1'b0;
  localparam logic             ADR_ALUOUT   = 1'b1;

  localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
  localparam logic [SEL_W-1:0] SRC_A_OLDPC  = 2'b01;
  localparam logic [SEL_W-1:0] SRC_A_RD1    = 2'b10;
  localparam logic [SEL_W-1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [SEL_W-1:0] SRC_B_RD2    = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_IMM    = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_READDATA  = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b1001;

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Maps the FSM's ALU mode plus funct3/funct7b5 onto the 4-bit ALU opcode.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_mode_t        alu_mode_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7b5_i,
  output logic [ALU_W-1:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_mode_i)
      ALU_MODE_ADD: alu_control_o = ALU_ADD;
      // Branch compares only need the funct3[2:1] pair; the low bit flips the sense.
      ALU_MODE_BRANCH: begin
        case (funct3_i[2:1])
          2'b10:   alu_control_o = ALU_SLT;
          2'b11:   alu_control_o = ALU_SLTU;
          default: alu_control_o = ALU_SUB;
        endcase
      end
      default: begin
        case (funct3_i)
          3'b000: alu_control_o = ((alu_mode_i == ALU_MODE_RTYPE) && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control_o = ALU_SLL;
          3'b010: alu_control_o = ALU_SLT;
          3'b011: alu_control_o = ALU_SLTU;
          3'b100: alu_control_o = ALU_XOR;
          3'b101: alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110: alu_control_o = ALU_OR;
          default: alu_control_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control unit: state register plus decoded datapath controls.
// Define MULTICYCLE_MEM_WAIT_EN to add mem_ready and stall the memory states.
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic             adr_src,
  output logic [SEL_W-1:0] alu_src_a,
  output logic [SEL_W-1:0] alu_src_b,
  output logic [SEL_W-1:0] result_src,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal_instr,
  output logic             retire
);

  state_t    state_q, state_d;
  alu_mode_t alu_mode_c;
  logic      mem_ok_c;
  logic      pc_write_c, ir_write_c, mem_write_c, reg_write_c, illegal_c, retire_c;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_ok_c = mem_ready;
`else
  assign mem_ok_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next state and Moore decode; memory states hold until the access completes.
  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    retire_c    = 1'b0;
    adr_src     = ADR_PC;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RD2;
    result_src  = RES_ALUOUT;
    alu_mode_c  = ALU_MODE_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURESULT;
        ir_write_c = mem_ok_c;
        pc_write_c = mem_ok_c;
        if (mem_ok_c) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = ADR_ALUOUT;
        if (mem_ok_c) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_READDATA;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = ADR_ALUOUT;
        mem_write_c = mem_ok_c;
        retire_c    = mem_ok_c;
        if (mem_ok_c) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a  = SRC_A_RD1;
        alu_mode_c = ALU_MODE_RTYPE;
        state_d    = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = SRC_A_RD1;
        alu_src_b  = SRC_B_IMM;
        alu_mode_c = ALU_MODE_ITYPE;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RD1;
        alu_mode_c = ALU_MODE_BRANCH;
        pc_write_c = zero ^ funct3[0] ^ funct3[2];
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        state_d   = S_JAL;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_mode_i    (alu_mode_c),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .alu_control_o (alu_control)
  );

  // Strobes are suppressed for the whole reset window.
  assign pc_write      = pc_write_c  & ~rst;
  assign ir_write      = ir_write_c  & ~rst;
  assign mem_write     = mem_write_c & ~rst;
  assign reg_write     = reg_write_c & ~rst;
  assign illegal_instr = illegal_c   & ~rst;
  assign retire        = retire_c    & ~rst;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: table of instructions expanded into
// per-cycle expected control vectors on a scoreboard queue, plus reset/wait sequences.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [3:0] alu;
    logic       illegal;
    logic       retire;
  } outs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic [3:0] alu;
    logic       pcw;
  } vec_t;

  typedef enum {
    E_FETCH, E_FETCH_NOSTB, E_DECODE, E_DECODE_ILL, E_MEMADR, E_MEMREAD, E_MEMWB,
    E_MEMWRITE, E_MEMWRITE_WAIT, E_EXECR, E_EXECI, E_ALUWB, E_BRANCH, E_JAL, E_JALR, E_LUI
  } est_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       pc_write, ir_write, mem_write, reg_write, adr_src, illegal_instr, retire;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_control;
  outs_t      act;

  int    checks   = 0;
  int    failures = 0;
  outs_t exp_q[$];
  vec_t  tbl[$];

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .mem_ready     (mem_ready),
`endif
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .adr_src       (adr_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .alu_control   (alu_control),
    .illegal_instr (illegal_instr),
    .retire        (retire)
  );

  assign act = {pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a, alu_src_b,
                result_src, alu_control, illegal_instr, retire};

  // Expected control vector for one state, written straight from the state table.
  function automatic outs_t ev(input est_t st, input vec_t v);
    outs_t e;
    e = '0;
    case (st)
      E_FETCH:         begin e.ir_write = 1'b1; e.pc_write = 1'b1; e.b = 2'b10; e.rs = 2'b10; end
      E_FETCH_NOSTB:   begin e.b = 2'b10; e.rs = 2'b10; end
      E_DECODE:        begin e.a = 2'b01; e.b = 2'b01; end
      E_DECODE_ILL:    begin e.a = 2'b01; e.b = 2'b01; e.illegal = 1'b1; end
      E_MEMADR:        begin e.a = 2'b10; e.b = 2'b01; end
      E_MEMREAD:       e.adr_src = 1'b1;
      E_MEMWB:         begin e.rs = 2'b01; e.reg_write = 1'b1; e.retire = 1'b1; end
      E_MEMWRITE:      begin e.adr_src = 1'b1; e.mem_write = 1'b1; e.retire = 1'b1; end
      E_MEMWRITE_WAIT: e.adr_src = 1'b1;
      E_EXECR:         begin e.a = 2'b10; e.alu = v.alu; end
      E_EXECI:         begin e.a = 2'b10; e.b = 2'b01; e.alu = v.alu; end
      E_ALUWB:         begin e.reg_write = 1'b1; e.retire = 1'b1; end
      E_BRANCH:        begin e.a = 2'b10; e.alu = v.alu; e.pc_write = v.pcw; e.retire = 1'b1; end
      E_JAL:           begin e.a = 2'b01; e.b = 2'b10; e.pc_write = 1'b1; end
      E_JALR:          begin e.a = 2'b10; e.b = 2'b01; end
      E_LUI:           begin e.a = 2'b11; e.b = 2'b01; end
      default:         e = '0;
    endcase
    return e;
  endfunction

  function automatic void push(input est_t st, input vec_t v);
    exp_q.push_back(ev(st, v));
  endfunction

  // Full expected trace of one instruction, starting in FETCH.
  function automatic void push_seq(input vec_t v);
    push(E_FETCH, v);
    case (v.op)
      7'b0000011: begin push(E_DECODE, v); push(E_MEMADR, v); push(E_MEMREAD, v); push(E_MEMWB, v); end
      7'b0100011: begin push(E_DECODE, v); push(E_MEMADR, v); push(E_MEMWRITE, v); end
      7'b0110011: begin push(E_DECODE, v); push(E_EXECR, v); push(E_ALUWB, v); end
      7'b0010011: begin push(E_DECODE, v); push(E_EXECI, v); push(E_ALUWB, v); end
      7'b1100011: begin push(E_DECODE, v); push(E_BRANCH, v); end
      7'b1101111: begin push(E_DECODE, v); push(E_JAL, v); push(E_ALUWB, v); end
      7'b1100111: begin push(E_DECODE, v); push(E_JALR, v); push(E_JAL, v); push(E_ALUWB, v); end
      7'b0110111: begin push(E_DECODE, v); push(E_LUI, v); push(E_ALUWB, v); end
      default:    push(E_DECODE_ILL, v);
    endcase
  endfunction

  function automatic void add(input string n, input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, input logic z, input logic [3:0] alu, input logic pcw);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.alu = alu; v.pcw = pcw;
    tbl.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    opcode = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
  endtask

  // Compare one cycle against the head of the scoreboard, then step to the next cycle.
  task automatic check_cycle(input string name, input int idx);
    outs_t e;
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s cyc%0d: scoreboard empty, got %h", name, idx, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL %s cyc%0d: got %h required %h", name, idx, act, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) check_cycle(name, i);
  endtask

  task automatic run_instr(input vec_t v);
    apply(v);
    push_seq(v);
    drain(v.name);
  endtask

  initial begin
    vec_t v;
    add("add",   7'b0110011, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
    add("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 4'b0001, 1'b0);
    add("sll",   7'b0110011, 3'b001, 1'b0, 1'b0, 4'b0111, 1'b0);
    add("slt",   7'b0110011, 3'b010, 1'b0, 1'b0, 4'b0101, 1'b0);
    add("sltu",  7'b0110011, 3'b011, 1'b0, 1'b0, 4'b1000, 1'b0);
    add("xor",   7'b0110011, 3'b100, 1'b0, 1'b0, 4'b1001, 1'b0);
    add("sra",   7'b0110011, 3'b101, 1'b1, 1'b0, 4'b0100, 1'b0);
    add("or",    7'b0110011, 3'b110, 1'b0, 1'b0, 4'b0011, 1'b0);
    add("and",   7'b0110011, 3'b111, 1'b0, 1'b0, 4'b0010, 1'b0);
    add("addi",  7'b0010011, 3'b000, 1'b1, 1'b0, 4'b0000, 1'b0);
    add("srai",  7'b0010011, 3'b101, 1'b1, 1'b0, 4'b0100, 1'b0);
    add("srli",  7'b0010011, 3'b101, 1'b0, 1'b0, 4'b0110, 1'b0);
    add("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 4'b0001, 1'b1);
    add("bne_z", 7'b1100011, 3'b001, 1'b0, 1'b1, 4'b0001, 1'b0);
    add("bne_n", 7'b1100011, 3'b001, 1'b0, 1'b0, 4'b0001, 1'b1);
    add("blt",   7'b1100011, 3'b100, 1'b0, 1'b0, 4'b0101, 1'b1);
    add("bge",   7'b1100011, 3'b101, 1'b0, 1'b0, 4'b0101, 1'b0);
    add("bltu",  7'b1100011, 3'b110, 1'b0, 1'b0, 4'b1000, 1'b1);
    add("bgeu",  7'b1100011, 3'b111, 1'b0, 1'b1, 4'b1000, 1'b1);
    add("lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 4'b0000, 1'b0);
    add("sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 4'b0000, 1'b0);
    add("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
    add("jalr",  7'b1100111, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
    add("lui",   7'b0110111, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
    add("ill7f", 7'b1111111, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
    add("ill00", 7'b0000000, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);

    rst = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    @(posedge clk);
    #1;
    push(E_FETCH_NOSTB, tbl[0]);
    check_cycle("reset", 0);
    rst = 1'b0;

    foreach (tbl[i]) run_instr(tbl[i]);

    // Abort an R-type in EXECUTER: strobes stay low under reset, then a clean FETCH.
    v = tbl[1];
    apply(v);
    push(E_FETCH, v); push(E_DECODE, v);
    drain("rst_pre");
    rst = 1'b1;
    push(E_EXECR, v);
    check_cycle("rst_exec", 0);
    push(E_FETCH_NOSTB, v);
    check_cycle("rst_fetch", 0);
    rst = 1'b0;
    run_instr(tbl[0]);

`ifdef MULTICYCLE_MEM_WAIT_EN
    // lw with three wait cycles in MEMREAD: 8 cycles total.
    v = tbl[19];
    apply(v);
    push(E_FETCH, v); push(E_DECODE, v); push(E_MEMADR, v);
    drain("lw_wait_a");
    mem_ready = 1'b0;
    push(E_MEMREAD, v); push(E_MEMREAD, v); push(E_MEMREAD, v);
    drain("lw_wait_hold");
    mem_ready = 1'b1;
    push(E_MEMREAD, v); push(E_MEMWB, v);
    drain("lw_wait_done");

    // FETCH stalled: no ir_write/pc_write until mem_ready.
    v = tbl[0];
    apply(v);
    mem_ready = 1'b0;
    push(E_FETCH_NOSTB, v); push(E_FETCH_NOSTB, v);
    drain("fetch_wait");
    mem_ready = 1'b1;
    run_instr(v);

    // sw stalled in MEMWRITE: mem_write and retire only on the ready cycle.
    v = tbl[20];
    apply(v);
    push(E_FETCH, v); push(E_DECODE, v); push(E_MEMADR, v);
    drain("sw_wait_a");
    mem_ready = 1'b0;
    push(E_MEMWRITE_WAIT, v); push(E_MEMWRITE_WAIT, v);
    drain("sw_wait_hold");
    mem_ready = 1'b1;
    push(E_MEMWRITE, v);
    drain("sw_wait_done");
    run_instr(tbl[23]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 Parameters: none; all behaviour SHALL be fixed by this document and the macro in Configuration.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 opcode  in  7  instruction[6:0] from the instruction register.
REQ-005 funct3  in  3  instruction[14:12].
REQ-006 funct7b5  in  1  instruction[30].
REQ-007 zero  in  1  ALU Zero flag (combinational, current cycle).
REQ-008 mem_ready  in  1  memory access complete; present only with MEM_WAIT_EN.
REQ-009 pc_write, ir_write, mem_write, reg_write  out  1 each  write strobes.
REQ-010 adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-011 alu_src_a  out  2  select: 00=PC, 01=OldPC, 10=RD1, 11=zero.
REQ-012 alu_src_b  out  2  select: 00=RD2, 01=ImmExt, 10=constant 4.
REQ-013 result_src  out  2  select: 00=ALUOut, 01=ReadData, 10=ALUResult.
REQ-014 alu_control  out  4  ALU opcode: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sra, 0101 slt, 0110 srl, 0111 sll, 1000 sltu, 1001 xor.
REQ-015 illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
REQ-016 retire  out  1  one-cycle pulse in the final state of each instruction.

Function
REQ-017 Outputs SHALL be Moore outputs (decoded from state, opcode and funct fields only); the only exceptions SHALL be branch pc_write, which also depends on zero, and, with MEM_WAIT_EN, the strobes of REQ-036, which also depend on mem_ready.
REQ-018 Unlisted outputs SHALL be 0/00/0000 in every state.
REQ-019 FETCH: adr_src=0, ir_write=1, a=00, b=10, add, result_src=10, pc_write=1 -> DECODE.
REQ-020 DECODE: a=01, b=01, add (branch/jal target into ALUOut); next state by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BRANCH, 1101111 -> JAL, 1100111 -> JALR, 0110111 -> LUI, any other -> FETCH with illegal_instr=1.
REQ-021 MEMADR: a=10, b=01, add -> MEMREAD if opcode[5]=0, else MEMWRITE.
REQ-022 MEMREAD: adr_src=1, result_src=00 -> MEMWB; MEMWB: result_src=01, reg_write=1, retire=1 -> FETCH.
REQ-023 MEMWRITE: adr_src=1, result_src=00, mem_write=1, retire=1 -> FETCH.
REQ-024 EXECUTER: a=10, b=00, alu_control from R-type decode -> ALUWB; EXECUTEI: a=10, b=01, I-type decode -> ALUWB.
REQ-025 ALUWB: result_src=00, reg_write=1, retire=1 -> FETCH.
REQ-026 R/I decode by funct3: 000 add (sub if R and funct7b5), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (sra if funct7b5, both R and I), 110 or, 111 and.
REQ-027 BRANCH: a=10, b=00, alu_control = sub for funct3[2:1]=00, slt for 10, sltu for 11; result_src=00; pc_write = zero ^ funct3[0] ^ funct3[2]; retire=1 -> FETCH.
REQ-028 JAL: a=01, b=10, add, result_src=00, pc_write=1 -> ALUWB (writes OldPC+4 to rd).
REQ-029 JALR: a=10, b=01, add -> JAL; the target LSB is not cleared by this block.
REQ-030 LUI: a=11, b=01, add -> ALUWB.
REQ-031 Cycle counts: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 4, illegal 2.

Reset
REQ-032 While rst=1 at a rising edge, state SHALL become FETCH regardless of the current state, aborting any in-flight instruction.
REQ-033 While rst=1, pc_write, ir_write, mem_write, reg_write, illegal_instr and retire SHALL be forced to 0.
REQ-034 In the first cycle after rst deasserts, FETCH outputs SHALL be driven.

Configuration
REQ-035 Macro MULTICYCLE_MEM_WAIT_EN SHALL gate the mem_ready port and wait-state logic.
REQ-036 With the macro: FETCH, MEMREAD and MEMWRITE SHALL hold state while mem_ready=0, asserting ir_write, pc_write and mem_write only in the cycle mem_ready=1; without the macro, every memory state SHALL be a single cycle.

Structure
REQ-037 Package mc_ctrl_pkg SHALL hold the state enum, opcode constants, select encodings and the 4-bit ALU opcode constants.
REQ-038 Sub-module alu_decoder SHALL map a mode (add/funct/branch), funct3 and funct7b5 to alu_control.

Verification
REQ-039 Reset in EXECUTER: rst=1 for one edge -> state FETCH, all strobes 0 while rst=1.
REQ-040 add x3,x1,x2 (0110011, f3=000, f7b5=0) -> 4 cycles, alu_control 0000 in EXECUTER, reg_write=1 in ALUWB; with f7b5=1 -> 0001.
REQ-041 srai (0010011, f3=101, f7b5=1) -> alu_control 0100; srli (f7b5=0) -> 0110.
REQ-042 bne (f3=001): zero=1 -> pc_write=0; zero=0 -> pc_write=1; bltu (f3=110): alu_control 1000, zero=0 -> pc_write=1.
REQ-043 lw with MULTICYCLE_MEM_WAIT_EN, mem_ready held 0 for 3 cycles in MEMREAD -> state held, then MEMWB; total 8 cycles.
REQ-044 opcode 1111111 -> illegal_instr=1 in DECODE, FETCH next cycle, no reg_write, mem_write or retire.
